motor_drive_sequencer: RTL and testbench
========================================

Name: motor_drive_sequencer

Overview:
- Sequences the DC motor driver's MOTOR_DIR / MOTOR_EN pair from a command interface.
- Generates PWM on MOTOR_EN and ramps duty up and down by a fixed step per PWM period.
- Forces ramp-down, then enforced dead time, before any direction reversal.
- Sits between the command source (switch/UART decoder) and the H-bridge pins; replaces direct SW/BTN drive.

Parameters:
- PWM_DIV, 16'd487, prescaler: PWM counter advances once every PWM_DIV+1 CLK cycles.
- RAMP_STEP, 8'd4, duty change applied at each PWM period end while ramping.
- DEAD_TIME, 27'd124999999, CLK cycles MOTOR_EN is held low between direction states.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY.
- CMD_DIR  in  1  requested direction.
- CMD_DUTY  in  8  requested duty; 0 means stop.
- ESTOP  in  1  level emergency stop.
- MOTOR_DIR  out  1  H-bridge direction.
- MOTOR_EN  out  1  H-bridge enable (PWM).
- CUR_DUTY  out  8  duty currently applied.
- BUSY  out  1  high in any state except IDLE and RUN.

Behaviour:
- Reset: asynchronous, active-low. State=IDLE, MOTOR_DIR=0, MOTOR_EN=0, CUR_DUTY=0, target_dir=0, target_duty=0, prescaler=0, pwm_cnt=0, dead_cnt=0.
- PWM generation:
  - 8-bit pwm_cnt increments on each prescaler tick and wraps 255->0; it free-runs and is never reset by commands.
  - period_end = tick & pwm_cnt==255.
  - en_raw = (pwm_cnt < CUR_DUTY) & state!=DEAD, registered (1-cycle latency).
  - MOTOR_EN = en_reg & ~ESTOP. The ESTOP gate is combinational, so cut-off has zero latency.
  - Duty 255 gives EN low 1 tick per period; duty 0 gives EN constantly low.
- Command handshake:
  - CMD_READY = (state!=DEAD) & ~ESTOP, combinational.
  - On accept, target_dir and target_duty are loaded.
  - A new accept overwrites the previous target; there is no queue.
  - A target accepted in the same cycle as period_end takes effect at the next period_end.
- Ramp rule at period_end:
  - Up: CUR_DUTY = (target - CUR_DUTY > RAMP_STEP) ? CUR_DUTY + RAMP_STEP : target.
  - Down: symmetric.
  - No wrap; arithmetic is 9-bit internally.
- States (evaluated each cycle; duty changes only at period_end):
  - IDLE: CUR_DUTY=0.
    - target_dir!=MOTOR_DIR -> DEAD.
    - else target_duty!=0 -> RAMP.
  - RAMP: direction matches and CUR_DUTY moves toward target_duty.
    - target_dir!=MOTOR_DIR -> BRAKE.
    - CUR_DUTY==target_duty -> RUN, or IDLE if target is 0.
  - RUN: steady.
    - target_dir!=MOTOR_DIR -> BRAKE.
    - target_duty!=CUR_DUTY -> RAMP.
  - BRAKE: ramp CUR_DUTY toward 0.
    - At 0 -> DEAD.
    - A command that restores target_dir==MOTOR_DIR aborts the brake -> RAMP. No dead time, and DIR is untouched.
  - DEAD: CUR_DUTY=0, EN=0, and dead_cnt counts from 0.
    - When dead_cnt==DEAD_TIME: MOTOR_DIR<=target_dir, dead_cnt<=0, then -> IDLE.
    - DEAD therefore lasts DEAD_TIME+1 cycles.
    - Afterwards IDLE re-evaluates the target (RAMP if duty!=0).
- ESTOP (level):
  - On assertion, from any state: CUR_DUTY<=0, target_duty<=0, state<=DEAD, dead_cnt held at 0 while ESTOP=1.
  - Counting starts the cycle after release; then DEAD->IDLE.
  - MOTOR_DIR is unchanged unless target_dir differed.
- Invariants:
  - MOTOR_DIR changes only on DEAD exit.
  - MOTOR_EN is 0 for at least DEAD_TIME+1 cycles before and after any MOTOR_DIR change.

Decomposition:
- Package motor_pkg holds:
  - state enum IDLE/RAMP/RUN/BRAKE/DEAD (3-bit);
  - DUTY_W=8;
  - DEAD_W=27.
- Sub-module motor_pwm_gen (prescaler, pwm_cnt, compare, period_end strobe; inputs CLK, RST_N, duty, enable).
- The sequencer keeps the FSM, targets, ramp and dead counter.

Test Plan (PWM_DIV=0, RAMP_STEP=64, DEAD_TIME=10):
- Idle start, cmd DIR=0 DUTY=200 -> CUR_DUTY 64,128,192,200 at successive period_ends, then RUN. EN high 200 of every 256 cycles, no DEAD entered.
- In RUN@200, cmd DIR=1 DUTY=100 -> CUR_DUTY 136,72,8,0, then DEAD with EN=0 for ≥11 cycles. DIR goes to 1 on exit, then duty 64,100 -> RUN.
- During BRAKE (CUR_DUTY=72), cmd DIR=0 DUTY=150 -> RAMP 136,150. DIR never toggles, DEAD never entered.
- ESTOP asserted mid-RAMP -> MOTOR_EN=0 same cycle, CMD_READY=0, CUR_DUTY=0. After release, 11 cycles DEAD, then IDLE with BUSY=0.
- RST_N pulsed low mid-RUN (asynchronous, not at CLK edge) -> EN=0, DIR=0, CUR_DUTY=0 immediately, and CMD_READY=1 after release.
- Boundaries: DUTY=255 -> EN low exactly 1 cycle per period; then DUTY=0 -> ramp to 0, IDLE, EN constantly 0. A command accepted on the period_end cycle is applied one period later.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types, widths and the duty-ramp helper for the motor drive sequencer.
package motor_pkg;

    localparam int DUTY_W = 8;
    localparam int DEAD_W = 27;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        RUN   = 3'd2,
        BRAKE = 3'd3,
        DEAD  = 3'd4
    } state_t;

    // One ramp step from cur toward tgt; the gap is measured in 9 bits so it never wraps.
    function automatic logic [DUTY_W-1:0] ramp_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] tgt,
        input logic [DUTY_W-1:0] step
    );
        logic [DUTY_W:0] gap;
        if (tgt > cur) begin
            gap = {1'b0, tgt} - {1'b0, cur};
            ramp_toward = (gap > {1'b0, step}) ? cur + step : tgt;
        end else begin
            gap = {1'b0, cur} - {1'b0, tgt};
            ramp_toward = (gap > {1'b0, step}) ? cur - step : tgt;
        end
    endfunction

endpackage

// File: rtl/motor_pwm_gen.sv
// Free-running PWM timebase: prescaler, 8-bit period counter, registered compare output.
module motor_pwm_gen
    import motor_pkg::*;
#(
    parameter logic [15:0] PWM_DIV = 16'd487
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DUTY_W-1:0] duty,
    input  logic              enable,
    output logic              pwm_out,
    output logic              period_end
);

    logic [15:0]       prescaler;
    logic [DUTY_W-1:0] pwm_cnt;
    logic              tick;

    assign tick       = (prescaler == PWM_DIV);
    assign period_end = tick && (pwm_cnt == '1);

    // pwm_cnt is never cleared by commands, so the period phase only depends on reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
            pwm_out   <= 1'b0;
        end else begin
            if (tick) begin
                prescaler <= '0;
                pwm_cnt   <= pwm_cnt + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            pwm_out <= enable && (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/motor_drive_sequencer.sv
// Command-driven H-bridge sequencer: duty ramping, braking before reversal, dead time, ESTOP.
module motor_drive_sequencer
    import motor_pkg::*;
#(
    parameter logic [15:0]       PWM_DIV   = 16'd487,
    parameter logic [DUTY_W-1:0] RAMP_STEP = 8'd4,
    parameter logic [DEAD_W-1:0] DEAD_TIME = 27'd124999999
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_DIR,
    input  logic [DUTY_W-1:0] CMD_DUTY,
    input  logic              ESTOP,
    output logic              MOTOR_DIR,
    output logic              MOTOR_EN,
    output logic [DUTY_W-1:0] CUR_DUTY,
    output logic              BUSY
);

    state_t            state;
    logic              target_dir;
    logic [DUTY_W-1:0] target_duty;
    logic [DEAD_W-1:0] dead_cnt;
    logic              en_reg;
    logic              period_end;
    logic              pwm_enable;
    logic              accept;
    logic              dir_match;

    // Handshake: a command transfers on any cycle where CMD_VALID && CMD_READY; READY drops
    // during dead time and ESTOP. An accepted command simply replaces the current target.
    assign CMD_READY  = (state != DEAD) && !ESTOP;
    assign accept     = CMD_VALID && CMD_READY;
    assign dir_match  = (target_dir == MOTOR_DIR);
    assign pwm_enable = (state != DEAD);
    assign MOTOR_EN   = en_reg && !ESTOP;
    assign BUSY       = (state != IDLE) && (state != RUN);

    motor_pwm_gen #(
        .PWM_DIV(PWM_DIV)
    ) u_pwm (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .duty      (CUR_DUTY),
        .enable    (pwm_enable),
        .pwm_out   (en_reg),
        .period_end(period_end)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            MOTOR_DIR   <= 1'b0;
            CUR_DUTY    <= '0;
            target_dir  <= 1'b0;
            target_duty <= '0;
            dead_cnt    <= '0;
        end else if (ESTOP) begin
            state       <= DEAD;
            CUR_DUTY    <= '0;
            target_duty <= '0;
            dead_cnt    <= '0;
        end else begin
            // FSM below sees the pre-accept target, so a command on a period_end lands one period later.
            if (accept) begin
                target_dir  <= CMD_DIR;
                target_duty <= CMD_DUTY;
            end
            case (state)
                IDLE: begin
                    CUR_DUTY <= '0;
                    if (!dir_match) begin
                        state    <= DEAD;
                        dead_cnt <= '0;
                    end else if (target_duty != '0) begin
                        state <= RAMP;
                    end
                end
                RAMP: begin
                    if (!dir_match) begin
                        state <= BRAKE;
                    end else if (CUR_DUTY == target_duty) begin
                        state <= (target_duty == '0) ? IDLE : RUN;
                    end else if (period_end) begin
                        CUR_DUTY <= ramp_toward(CUR_DUTY, target_duty, RAMP_STEP);
                    end
                end
                RUN: begin
                    if (!dir_match) begin
                        state <= BRAKE;
                    end else if (target_duty != CUR_DUTY) begin
                        state <= RAMP;
                    end
                end
                BRAKE: begin
                    // Direction restored mid-brake: resume ramping with no dead time.
                    if (dir_match) begin
                        state <= RAMP;
                    end else if (CUR_DUTY == '0) begin
                        state    <= DEAD;
                        dead_cnt <= '0;
                    end else if (period_end) begin
                        CUR_DUTY <= ramp_toward(CUR_DUTY, '0, RAMP_STEP);
                    end
                end
                DEAD: begin
                    CUR_DUTY <= '0;
                    if (dead_cnt == DEAD_TIME) begin
                        MOTOR_DIR <= target_dir;
                        dead_cnt  <= '0;
                        state     <= IDLE;
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    CUR_DUTY <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Bench for motor_drive_sequencer: directed scenarios plus random commands vs a trajectory model.
module tb_motor_drive_sequencer;

    localparam int STEP = 64;
    localparam int DT   = 10;
    localparam int PER  = 256;

    logic       CLK       = 1'b0;
    logic       RST_N     = 1'b1;
    logic       CMD_VALID = 1'b0;
    logic       CMD_DIR   = 1'b0;
    logic [7:0] CMD_DUTY  = 8'd0;
    logic       ESTOP     = 1'b0;
    logic       CMD_READY;
    logic       MOTOR_DIR;
    logic       MOTOR_EN;
    logic [7:0] CUR_DUTY;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    motor_drive_sequencer #(
        .PWM_DIV  (16'd0),
        .RAMP_STEP(8'd64),
        .DEAD_TIME(27'd10)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_DIR  (CMD_DIR),
        .CMD_DUTY (CMD_DUTY),
        .ESTOP    (ESTOP),
        .MOTOR_DIR(MOTOR_DIR),
        .MOTOR_EN (MOTOR_EN),
        .CUR_DUTY (CUR_DUTY),
        .BUSY     (BUSY)
    );

    // ---------------- clock / reset-relative phase ----------------
    always #5 CLK = ~CLK;

    int cyc;  // posedges since reset release; equals the PWM counter value with PWM_DIV=0
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ---------------- observation monitor ----------------
    int         ns = 0;
    int         en_hi_total = 0;
    int         en_low_run = 0;
    int         bad_phase = 0;
    int         zero_at = -1;
    int         dir_chg_at = -1;
    int         dir_chg_cnt = 0;
    int         low_before_dir = 0;
    int         rise_after_dir = -1;
    logic [7:0] prev_duty = 8'd0;
    logic       prev_dir = 1'b0;
    logic       prev_en = 1'b0;
    int         seen_q[$];
    logic [7:0] exp_q[$];

    always @(negedge CLK) begin
        ns++;
        if (RST_N) begin
            if (CUR_DUTY !== prev_duty) begin
                seen_q.push_back(int'(CUR_DUTY));
                if (cyc % PER != 0) bad_phase++;
                if (CUR_DUTY == 8'd0) zero_at = ns;
            end
            if (MOTOR_DIR !== prev_dir) begin
                dir_chg_cnt++;
                dir_chg_at     = ns;
                low_before_dir = en_low_run;
                rise_after_dir = -1;
            end
            if (MOTOR_EN && !prev_en && rise_after_dir < 0 && dir_chg_at >= 0) rise_after_dir = ns;
        end
        if (MOTOR_EN) begin
            en_hi_total++;
            en_low_run = 0;
        end else begin
            en_low_run++;
        end
        prev_duty = CUR_DUTY;
        prev_dir  = MOTOR_DIR;
        prev_en   = MOTOR_EN;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_min(input string tag, input int obs, input int minv);
        checks++;
        assert (obs >= minv) else begin
            errors++;
            $error("FAIL %s observed %0d expected at least %0d", tag, obs, minv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic dir, input logic [7:0] duty);
        check("cmd_ready", CMD_READY, 1);
        CMD_VALID = 1'b1;
        CMD_DIR   = dir;
        CMD_DUTY  = duty;
        step(1);
        CMD_VALID = 1'b0;
    endtask

    task automatic settle(input string tag);
        int quiet  = 0;
        int budget = 30 * PER;
        step(3);
        while (quiet < 3 && budget > 0) begin
            step(1);
            budget--;
            if (BUSY === 1'b0) quiet++;
            else quiet = 0;
        end
        check({tag, "_settled"}, quiet, 3);
    endtask

    task automatic wait_duty(input string tag, input logic [7:0] val);
        int budget = 20 * PER;
        while (CUR_DUTY !== val && budget > 0) begin
            step(1);
            budget--;
        end
        check({tag, "_reach"}, CUR_DUTY, val);
    endtask

    task automatic wait_en(input string tag);
        int budget = 2 * PER;
        while (MOTOR_EN !== 1'b1 && budget > 0) begin
            step(1);
            budget--;
        end
        check({tag, "_en_hi"}, MOTOR_EN, 1);
    endtask

    task automatic en_period(input string tag, input int duty);
        int e0 = en_hi_total;
        step(PER);
        check({tag, "_en_count"}, en_hi_total - e0, duty);
    endtask

    // ---------------- reference model ----------------
    // Expected CUR_DUTY values, one per period end, while moving from 'from' to 'to'.
    function automatic void push_ramp(input int from, input int to);
        int d = from;
        while (d != to) begin
            if (to > d) d = (to - d > STEP) ? d + STEP : to;
            else        d = (d - to > STEP) ? d - STEP : to;
            exp_q.push_back(8'(d));
        end
    endfunction

    logic m_dir  = 1'b0;
    int   m_duty = 0;

    task automatic clear_obs();
        seen_q.delete();
        exp_q.delete();
        bad_phase = 0;
    endtask

    task automatic compare_traj(input string tag);
        check({tag, "_len"}, seen_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
            check($sformatf("%s_d%0d", tag, i), seen_q[i], exp_q[i]);
        check({tag, "_phase"}, bad_phase, 0);
    endtask

    // Issue one command from a settled state and compare the whole duty/direction outcome.
    task automatic do_cmd(input string tag, input logic dir, input logic [7:0] duty);
        int chg0 = dir_chg_cnt;
        logic rev;
        rev = (dir != m_dir);
        clear_obs();
        if (rev) begin
            push_ramp(m_duty, 0);
            push_ramp(0, int'(duty));
        end else begin
            push_ramp(m_duty, int'(duty));
        end
        send(dir, duty);
        settle(tag);
        compare_traj(tag);
        check({tag, "_dir"}, MOTOR_DIR, dir);
        check({tag, "_dir_changes"}, dir_chg_cnt - chg0, rev ? 1 : 0);
        if (rev) begin
            check_min({tag, "_low_before_rev"}, low_before_dir, DT + 1);
            if (duty != 8'd0) check_min({tag, "_low_after_rev"}, rise_after_dir - dir_chg_at, DT + 1);
        end
        check({tag, "_duty"}, CUR_DUTY, duty);
        en_period(tag, int'(duty));
        m_dir  = dir;
        m_duty = int'(duty);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed and random sequence ----------------
    initial begin
        int b;
        #2 RST_N = 1'b0;
        #1;
        check("rst_en", MOTOR_EN, 0);
        check("rst_dir", MOTOR_DIR, 0);
        check("rst_duty", CUR_DUTY, 0);
        check("rst_busy", BUSY, 0);
        check("rst_ready", CMD_READY, 1);
        step(2);
        RST_N = 1'b1;

        // Ramp up from idle, then reverse through brake and dead time
        do_cmd("up200", 1'b0, 8'd200);
        do_cmd("rev100", 1'b1, 8'd100);
        check("rev_dead_len", dir_chg_at - zero_at, DT + 2);

        // Brake aborted by restoring the direction
        do_cmd("up200b", 1'b1, 8'd200);
        clear_obs();
        push_ramp(200, 72);
        push_ramp(72, 150);
        b = dir_chg_cnt;
        send(1'b0, 8'd50);
        wait_duty("abort", 8'd72);
        send(1'b1, 8'd150);
        settle("abort");
        compare_traj("abort");
        check("abort_dir", MOTOR_DIR, 1);
        check("abort_no_rev", dir_chg_cnt - b, 0);
        m_duty = 150;

        // ESTOP mid-ramp; a command offered during ESTOP must be ignored
        send(1'b1, 8'd250);
        wait_duty("estop", 8'd214);
        wait_en("estop");
        ESTOP = 1'b1;
        #1;
        check("estop_en_now", MOTOR_EN, 0);
        check("estop_ready", CMD_READY, 0);
        CMD_VALID = 1'b1;
        CMD_DIR   = 1'b0;
        CMD_DUTY  = 8'd99;
        step(1);
        check("estop_duty", CUR_DUTY, 0);
        check("estop_busy", BUSY, 1);
        step(4);
        CMD_VALID = 1'b0;
        ESTOP     = 1'b0;
        step(10);
        check("estop_dead_hold", BUSY, 1);
        step(1);
        check("estop_dead_exit", BUSY, 0);
        step(3);
        check("estop_idle_busy", BUSY, 0);
        check("estop_idle_duty", CUR_DUTY, 0);
        check("estop_idle_dir", MOTOR_DIR, 1);
        m_duty = 0;

        // Asynchronous reset while running
        do_cmd("pre_rst", 1'b1, 8'd120);
        wait_en("pre_rst");
        #2 RST_N = 1'b0;
        #1;
        check("arst_en", MOTOR_EN, 0);
        check("arst_dir", MOTOR_DIR, 0);
        check("arst_duty", CUR_DUTY, 0);
        step(2);
        RST_N = 1'b1;
        step(1);
        check("arst_ready", CMD_READY, 1);
        check("arst_busy", BUSY, 0);
        m_dir  = 1'b0;
        m_duty = 0;

        // Full duty (EN low one cycle per period), then stop
        do_cmd("full", 1'b0, 8'd255);
        do_cmd("stop", 1'b0, 8'd0);

        // Command accepted exactly on the period_end cycle
        b = 2 * PER;
        while (cyc % PER != PER - 1 && b > 0) begin
            step(1);
            b--;
        end
        check("pe_align", cyc % PER, PER - 1);
        CMD_VALID = 1'b1;
        CMD_DIR   = 1'b0;
        CMD_DUTY  = 8'd100;
        step(1);
        CMD_VALID = 1'b0;
        check("pe_hold0", CUR_DUTY, 0);
        step(PER - 1);
        check("pe_hold_period", CUR_DUTY, 0);
        step(1);
        check("pe_first_step", CUR_DUTY, 64);
        settle("pe");
        check("pe_final", CUR_DUTY, 100);
        m_duty = 100;

        // Random commands at random phases
        for (int i = 0; i < 6; i++) begin
            step($urandom_range(0, 300));
            do_cmd($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
